// File: rtl/lcd_seq_gen.sv
// Table-driven LCD command/data sequencer: walks a delay+payload ROM and emits valid/ready beats.
// Define LCD_SEQ_FAST_SIM_EN to fix the delay unit at 8 cycles for simulation.
module lcd_seq_gen #(
  parameter int unsigned DATA_W  = 9,
  parameter int unsigned DLY_W   = 4,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned PRESC_W = 17,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                    clk_i,
  input  logic                    restn_i,
  input  logic                    start_i,
  input  logic                    ready_i,
  output logic [DATA_W-1:0]       data_o,
  output logic                    data_valid_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [ADDR_W-1:0]       rom_addr_o,
  input  logic [DLY_W+DATA_W-1:0] rom_data_i
);

`ifdef LCD_SEQ_FAST_SIM_EN
  localparam int unsigned PrescW = 3;
`else
  localparam int unsigned PrescW = PRESC_W;
`endif

  // ROM_LAT is limited to 1..3, so a 2-bit fetch counter always suffices.
  localparam logic [1:0] FetchLast = 2'(ROM_LAT);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDly,
    StValid,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [DATA_W-1:0]   payload_q, payload_d;
  logic [PrescW-1:0]   presc_q, presc_d;
  logic [DLY_W-1:0]    unit_q, unit_d;
  logic [1:0]          fcnt_q, fcnt_d;

  logic [DLY_W-1:0]    rom_dly;
  logic [DATA_W-1:0]   rom_payload;
  logic [DLY_W-1:0]    unit_inc;

  assign rom_dly     = rom_data_i[DLY_W+DATA_W-1:DATA_W];
  assign rom_payload = rom_data_i[DATA_W-1:0];
  assign unit_inc    = unit_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    dly_d     = dly_q;
    payload_d = payload_q;
    presc_d   = presc_q;
    unit_d    = unit_q;
    fcnt_d    = fcnt_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d  = '0;
          fcnt_d  = '0;
          state_d = StFetch;
        end
      end

      StFetch: begin
        if (fcnt_q == FetchLast) begin
          dly_d     = rom_dly;
          payload_d = rom_payload;
          presc_d   = '0;
          unit_d    = '0;
          if (rom_payload == '0) begin
            state_d = StDone;
          end else if (rom_dly == '0) begin
            state_d = StValid;
          end else begin
            state_d = StDly;
          end
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end

      StDly: begin
        presc_d = presc_q + 1'b1;
        // Unit counter stops at the programmed delay, so it cannot overflow.
        if (&presc_q) begin
          unit_d = unit_inc;
          if (unit_inc == dly_q) begin
            state_d = StValid;
          end
        end
      end

      StValid: begin
        if (ready_i) begin
          if (&addr_q) begin
            state_d = StDone;
          end else begin
            addr_d  = addr_q + 1'b1;
            fcnt_d  = '0;
            state_d = StFetch;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge restn_i) begin
    if (!restn_i) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      dly_q     <= '0;
      payload_q <= '0;
      presc_q   <= '0;
      unit_q    <= '0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      dly_q     <= dly_d;
      payload_q <= payload_d;
      presc_q   <= presc_d;
      unit_q    <= unit_d;
      fcnt_q    <= fcnt_d;
    end
  end

  // All outputs come straight from registers, so reset clears them without a clock edge.
  assign data_o       = payload_q;
  assign rom_addr_o   = addr_q;
  assign data_valid_o = (state_q == StValid);
  assign done_o       = (state_q == StDone);
  assign busy_o       = (state_q == StFetch) || (state_q == StDly) || (state_q == StValid);

endmodule

// File: tb/tb_lcd_seq_gen.sv
// Self-checking bench for lcd_seq_gen: 8-cycle delay unit (PRESC_W=3), ROM_LAT=1.
module tb_lcd_seq_gen;

  logic        clk_i = 1'b0;
  logic        restn_i;
  logic        start_i, ready_i;
  logic [8:0]  data_o;
  logic        data_valid_o, busy_o, done_o;
  logic [5:0]  rom_addr_o;
  logic [12:0] rom_data;
  logic [12:0] rom [64];

  logic        start2, ready2;
  logic [8:0]  data2;
  logic        valid2, busy2, done2;
  logic [1:0]  addr2;
  logic [12:0] rom2_data;
  logic [12:0] rom2 [4];

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) rom_data  <= rom[rom_addr_o];
  always @(posedge clk_i) rom2_data <= rom2[addr2];

  lcd_seq_gen #(
    .DATA_W(9), .DLY_W(4), .ADDR_W(6), .PRESC_W(3), .ROM_LAT(1)
  ) u_dut (
    .clk_i        (clk_i),
    .restn_i      (restn_i),
    .start_i      (start_i),
    .ready_i      (ready_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .rom_addr_o   (rom_addr_o),
    .rom_data_i   (rom_data)
  );

  lcd_seq_gen #(
    .DATA_W(9), .DLY_W(4), .ADDR_W(2), .PRESC_W(3), .ROM_LAT(1)
  ) u_dut2 (
    .clk_i        (clk_i),
    .restn_i      (restn_i),
    .start_i      (start2),
    .ready_i      (ready2),
    .data_o       (data2),
    .data_valid_o (valid2),
    .busy_o       (busy2),
    .done_o       (done2),
    .rom_addr_o   (addr2),
    .rom_data_i   (rom2_data)
  );

  typedef struct {
    int         edge_n;
    logic       start;
    logic       ready;
    logic       valid;
    logic [8:0] data;
    logic       busy;
    logic       done;
    logic [5:0] addr;
  } vec_t;

  vec_t vecs [21];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = '0;
  endtask

  // Each record is applied at edge edge_n (counted from the start edge E0) and the outputs
  // are sampled 1 time unit later. With extra=0 only the E0 start pulse is driven.
  task automatic run_vecs(input int lo, input int hi, input bit extra);
    int en;
    en = -1;
    for (int i = lo; i <= hi; i++) begin
      while (en < vecs[i].edge_n - 1) begin
        tick();
        en++;
      end
      start_i = vecs[i].start && (extra || vecs[i].edge_n == 0);
      ready_i = vecs[i].ready;
      tick();
      en++;
      start_i = 1'b0;
      chk($sformatf("vec%0d_valid", i), data_valid_o, vecs[i].valid);
      chk($sformatf("vec%0d_data",  i), data_o,       vecs[i].data);
      chk($sformatf("vec%0d_busy",  i), busy_o,       vecs[i].busy);
      chk($sformatf("vec%0d_done",  i), done_o,       vecs[i].done);
      chk($sformatf("vec%0d_addr",  i), rom_addr_o,   vecs[i].addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] exp5 [4];
    int hs;
    int done_edge;

    // Basic table {d2,0x038},{d0,0x00C},{d0,0x000}, ready tied high
    vecs[0]  = '{0,  1'b1, 1'b1, 1'b0, 9'h000, 1'b1, 1'b0, 6'd0};
    vecs[1]  = '{2,  1'b0, 1'b1, 1'b0, 9'h038, 1'b1, 1'b0, 6'd0};
    vecs[2]  = '{17, 1'b0, 1'b1, 1'b0, 9'h038, 1'b1, 1'b0, 6'd0};
    vecs[3]  = '{18, 1'b0, 1'b1, 1'b1, 9'h038, 1'b1, 1'b0, 6'd0};
    vecs[4]  = '{19, 1'b0, 1'b1, 1'b0, 9'h038, 1'b1, 1'b0, 6'd1};
    vecs[5]  = '{21, 1'b0, 1'b1, 1'b1, 9'h00C, 1'b1, 1'b0, 6'd1};
    vecs[6]  = '{22, 1'b0, 1'b1, 1'b0, 9'h00C, 1'b1, 1'b0, 6'd2};
    vecs[7]  = '{24, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b1, 6'd2};
    vecs[8]  = '{25, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 6'd2};
    // Start handling: {d1,0x011},{d0,0x022},{d0,0}; stray starts at E5 (DLY) and E17 (DONE)
    vecs[9]  = '{0,  1'b1, 1'b1, 1'b0, 9'h000, 1'b1, 1'b0, 6'd0};
    vecs[10] = '{5,  1'b1, 1'b1, 1'b0, 9'h011, 1'b1, 1'b0, 6'd0};
    vecs[11] = '{10, 1'b0, 1'b1, 1'b1, 9'h011, 1'b1, 1'b0, 6'd0};
    vecs[12] = '{11, 1'b0, 1'b1, 1'b0, 9'h011, 1'b1, 1'b0, 6'd1};
    vecs[13] = '{13, 1'b0, 1'b1, 1'b1, 9'h022, 1'b1, 1'b0, 6'd1};
    vecs[14] = '{16, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b1, 6'd2};
    vecs[15] = '{17, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 6'd2};
    vecs[16] = '{18, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 6'd2};
    // Empty table
    vecs[17] = '{0,  1'b1, 1'b1, 1'b0, 9'h000, 1'b1, 1'b0, 6'd0};
    vecs[18] = '{1,  1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 1'b0, 6'd0};
    vecs[19] = '{2,  1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b1, 6'd0};
    vecs[20] = '{3,  1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 6'd0};

    restn_i = 1'b0;
    start_i = 1'b0;
    ready_i = 1'b1;
    start2  = 1'b0;
    ready2  = 1'b1;
    clear_rom();
    for (int i = 0; i < 4; i++) rom2[i] = '0;
    #1;
    chk("rst_valid", data_valid_o, 1'b0);
    chk("rst_data",  data_o,       9'h000);
    chk("rst_busy",  busy_o,       1'b0);
    chk("rst_done",  done_o,       1'b0);
    chk("rst_addr",  rom_addr_o,   6'd0);
    chk("rst2_busy", busy2,        1'b0);
    repeat (3) tick();
    #3 restn_i = 1'b1;
    repeat (2) tick();

    rom[0] = {4'd2, 9'h038};
    rom[1] = {4'd0, 9'h00C};
    rom[2] = {4'd0, 9'h000};
    run_vecs(0, 8, 1'b1);
    repeat (2) tick();

    clear_rom();
    rom[0] = {4'd1, 9'h011};
    rom[1] = {4'd0, 9'h022};
    rom[2] = {4'd0, 9'h000};
    run_vecs(9, 16, 1'b1);
    repeat (2) tick();
    run_vecs(9, 16, 1'b0);
    repeat (2) tick();

    clear_rom();
    run_vecs(17, 20, 1'b1);
    repeat (2) tick();

    // Backpressure: VALID held for 50 cycles, then a single-cycle ready pulse
    clear_rom();
    rom[0] = {4'd0, 9'h055};
    rom[1] = {4'd0, 9'h066};
    ready_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (2) tick();
    for (int c = 0; c < 50; c++) begin
      chk($sformatf("bp%0d_valid", c), data_valid_o, 1'b1);
      chk($sformatf("bp%0d_data",  c), data_o,       9'h055);
      chk($sformatf("bp%0d_addr",  c), rom_addr_o,   6'd0);
      tick();
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("bp_hs_valid", data_valid_o, 1'b0);
    chk("bp_hs_addr",  rom_addr_o,   6'd1);
    repeat (2) tick();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp2_%0d_valid", c), data_valid_o, 1'b1);
      chk($sformatf("bp2_%0d_data",  c), data_o,       9'h066);
      chk($sformatf("bp2_%0d_addr",  c), rom_addr_o,   6'd1);
      tick();
    end
    ready_i = 1'b1;
    done_edge = -1;
    for (int c = 0; c < 20 && done_edge < 0; c++) begin
      tick();
      if (done_o) done_edge = c;
    end
    chk("bp_done_seen", (done_edge >= 0), 1'b1);
    repeat (2) tick();

    // Address end on the ADDR_W=2 instance: four entries, no end marker
    rom2[0] = {4'd0, 9'h101};
    rom2[1] = {4'd0, 9'h102};
    rom2[2] = {4'd0, 9'h103};
    rom2[3] = {4'd0, 9'h1FF};
    exp5[0] = 9'h101;
    exp5[1] = 9'h102;
    exp5[2] = 9'h103;
    exp5[3] = 9'h1FF;
    hs = 0;
    done_edge = -1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 1; c <= 40 && done_edge < 0; c++) begin
      if (valid2) begin
        if (hs < 4) chk($sformatf("end_hs%0d_data", hs), data2, exp5[hs]);
        hs++;
      end
      tick();
      if (done2) done_edge = c;
    end
    chk("end_handshakes", hs, 4);
    chk("end_done_edge",  done_edge, 12);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("end_post%0d_addr",  c), addr2,  2'd3);
      chk($sformatf("end_post%0d_valid", c), valid2, 1'b0);
      chk($sformatf("end_post%0d_busy",  c), busy2,  1'b0);
    end

    // Asynchronous reset in the middle of a d15 delay
    clear_rom();
    rom[0] = {4'd15, 9'h0AA};
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (20) tick();
    chk("mid_busy_pre", busy_o, 1'b1);
    chk("mid_data_pre", data_o, 9'h0AA);
    #3 restn_i = 1'b0;
    #1;
    chk("mid_rst_valid", data_valid_o, 1'b0);
    chk("mid_rst_data",  data_o,       9'h000);
    chk("mid_rst_busy",  busy_o,       1'b0);
    chk("mid_rst_done",  done_o,       1'b0);
    chk("mid_rst_addr",  rom_addr_o,   6'd0);
    #2 restn_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("post_rst%0d_busy", c), busy_o, 1'b0);
      chk($sformatf("post_rst%0d_done", c), done_o, 1'b0);
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("post_rst_restart_busy", busy_o, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_seq_gen.md
# lcd_seq_gen

- Parametrised, table-driven command/data sequencer for the LCD path.
- On `start_i`, walks a ROM table of entries starting at address 0. Each entry holds a delay field and a payload.
- For each entry: waits the programmed delay, presents the payload on a valid/ready interface, and advances to the next entry.
- Stops at an all-zero payload or at the last address, then pulses `done_o`. Sits between the init/command ROM and the LCD bus driver.

## Interface
- `DATA_W`, 9, payload width (LCD RS + 8-bit data).
- `DLY_W`, 4, delay field width.
- `ADDR_W`, 6, ROM address width.
- `PRESC_W`, 17, delay unit = 2^PRESC_W clock cycles.
- `ROM_LAT`, 1, ROM read latency in cycles (1..3).
- `clk_i`  in  1  clock.
- `restn_i`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  start request; sampled only in IDLE.
- `ready_i`  in  1  consumer ready.
- `data_o`  out  DATA_W  payload of current entry.
- `data_valid_o`  out  1  payload valid.
- `busy_o`  out  1  sequence in progress.
- `done_o`  out  1  one-cycle pulse at sequence end.
- `rom_addr_o`  out  ADDR_W  ROM address, registered.
- `rom_data_i`  in  DLY_W+DATA_W  ROM entry:
  - `[DLY_W+DATA_W-1:DATA_W]` = delay.
  - `[DATA_W-1:0]` = payload.

## Operation
- States: IDLE, FETCH, DLY, VALID, DONE.
- **IDLE**
  - `start_i`=1 -> `rom_addr_o`←0, FETCH.
  - Otherwise stay in IDLE.
- **FETCH**
  - Lasts exactly ROM_LAT+1 cycles, with `rom_addr_o` stable.
  - At the edge ending the last cycle, `rom_data_i` is captured into the delay and payload registers; `data_o` = payload register.
  - Payload == 0 -> DONE.
  - Else delay == 0 -> VALID.
  - Else -> DLY.
- **DLY**
  - Prescaler counts PRESC_W bits; each wrap increments the unit counter.
  - Unit counter == delay -> VALID.
  - Both counters clear on entry to DLY.
- **VALID**
  - `data_valid_o`=1; `data_o` held stable.
  - `ready_i`=1 at an edge is the handshake:
    - `rom_addr_o` == all-ones -> DONE (no wrap).
    - Else `rom_addr_o`+1, FETCH.
  - `ready_i` is ignored outside VALID.
- **DONE**
  - One cycle; `done_o`=1; -> IDLE.
- Output decode:
  - `busy_o`=1 in FETCH, DLY and VALID.
  - `busy_o`=0 in IDLE and DONE.
  - `data_valid_o` is decoded from state only.
- `start_i` in any state other than IDLE (including DONE) is ignored and is not queued.
- Delay arithmetic is unsigned. The unit counter is DLY_W bits and never overflows, because it stops at `delay`.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE.
  - `data_o`=0, `data_valid_o`=0, `busy_o`=0, `done_o`=0, `rom_addr_o`=0.
  - Prescaler and unit counter 0.
- Reset asserted mid-sequence aborts the sequence: no `done_o` pulse, and the sequence restarts only on a new `start_i`.
- Let E0 be the edge at which `start_i` is sampled. FETCH occupies E0..E(ROM_LAT+1).
- Entry with delay d:
  - DLY lasts d·2^PRESC_W cycles.
  - `data_valid_o` rises ROM_LAT+1+d·2^PRESC_W edges after FETCH entry.
- Handshake to next FETCH: 0 cycles. `data_valid_o` deasserts in the cycle after the handshake edge.
- With `ready_i` held high, each delay-0 entry costs ROM_LAT+2 cycles.
- End marker: DONE is entered ROM_LAT+1 edges after FETCH entry. `data_valid_o` is not asserted for the marker.

## Configuration
- `LCD_SEQ_FAST_SIM_EN`
  - Defined: the delay unit is fixed at 8 cycles (effective PRESC_W=3) regardless of the parameter; used for simulation.
  - Undefined: delay unit = 2^PRESC_W cycles.
- Nothing else changes; ports are identical in both builds.

## Test plan
All scenarios use ROM_LAT=1 and `LCD_SEQ_FAST_SIM_EN` defined (unit = 8 cycles).

1. **Basic table with `ready_i` tied 1.** Table {d2,0x038},{d0,0x00C},{d0,0x000}.
   - `data_valid_o` with `data_o`=0x038 in the cycle after E18.
   - `data_o`=0x00C valid after E21.
   - `done_o` high for one cycle after E24.
   - IDLE at E25.
   - `busy_o` low again from E24.
2. **Backpressure.** `ready_i`=0 for 50 cycles in VALID.
   - `data_valid_o` stays 1.
   - `data_o` and `rom_addr_o` stay unchanged.
   - `ready_i` pulse for 1 cycle -> exactly one address increment.
3. **Start handling.**
   - `start_i` pulsed during DLY and during DONE -> no effect.
   - `start_i` in IDLE after `done_o` -> sequence replays from address 0 with an identical output trace.
4. **Empty table.** Entry 0 payload 0.
   - `done_o` pulse after E2.
   - `data_valid_o` never asserted.
5. **Address end.** ADDR_W=2, four non-zero entries with d0, no end marker.
   - Exactly 4 handshakes, then `done_o`.
   - `rom_addr_o` stays 3 until next start; no 5th `data_valid_o`.
6. **Reset mid-delay.** `restn_i` low during DLY of a d15 entry.
   - All outputs 0 immediately, with no clock edge required.
   - After release, block stays in IDLE with `busy_o`=0 until `start_i`.
